// File: rtl/stim_gen_pkg.sv
// Shared types and helpers for the stim_gen_seq stimulus sequencer.
package stim_gen_pkg;

  typedef enum logic [1:0] {
    MODE_BIN   = 2'd0,
    MODE_GRAY  = 2'd1,
    MODE_WALK1 = 2'd2,
    MODE_WALK0 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2,
    FIN  = 2'd3
  } state_e;

  // Counting modes sweep the full input space; walking modes touch each bit once.
  function automatic int unsigned pass_len(mode_e mode, int width);
    if (mode == MODE_BIN || mode == MODE_GRAY) return 32'd1 << width;
    return 32'(width);
  endfunction

endpackage

// File: rtl/stim_gen_pattern.sv
// Combinational map from (mode, vector index) to the stimulus vector.
module stim_gen_pattern
  import stim_gen_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  mode_e              mode,
  input  logic [WIDTH-1:0]   vec_idx,
  output logic [WIDTH-1:0]   stim
);

  always_comb begin
    unique case (mode)
      MODE_BIN:   stim = vec_idx;
      MODE_GRAY:  stim = vec_idx ^ (vec_idx >> 1);
      MODE_WALK1: stim = WIDTH'(1) << vec_idx;
      MODE_WALK0: stim = ~(WIDTH'(1) << vec_idx);
      default:    stim = '0;
    endcase
  end

endmodule

// File: rtl/stim_gen_seq.sv
// Parametrised stimulus sequencer: binary/Gray/walking patterns, held and repeated.
// Optional feature macro STIM_GEN_PAUSE_EN adds a pause input that freezes RUN/TAIL.
module stim_gen_seq
  import stim_gen_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int REP_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef STIM_GEN_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [1:0]       mode,
  input  logic [REP_W-1:0] passes,
  output logic [WIDTH-1:0] stim,
  output logic             valid,
  output logic [WIDTH-1:0] vec_idx,
  output logic             busy,
  output logic             done
);

  localparam int HCW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [REP_W-1:0]   passes_q, passes_d;
  logic [REP_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [HCW-1:0]     hold_q, hold_d;
  logic [WIDTH-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   last_idx;
  logic [WIDTH-1:0]   pattern;
  logic               stall;

`ifdef STIM_GEN_PAUSE_EN
  assign stall = pause && (state_q == RUN || state_q == TAIL);
`else
  assign stall = 1'b0;
`endif

  assign last_idx = WIDTH'(pass_len(mode_q, WIDTH) - 1);

  always_comb begin
    // NOTE: every target gets its default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    mode_d     = mode_q;
    passes_d   = passes_q;
    pass_cnt_d = pass_cnt_q;
    hold_d     = hold_q;
    idx_d      = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          mode_d     = mode_e'(mode);
          passes_d   = (passes == '0) ? REP_W'(1) : passes;
          pass_cnt_d = '0;
          hold_d     = '0;
          idx_d      = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (idx_q == last_idx) begin
              idx_d = '0;
              if (pass_cnt_q == passes_q - REP_W'(1)) state_d = TAIL;
              else                                     pass_cnt_d = pass_cnt_q + REP_W'(1);
            end else begin
              idx_d = idx_q + WIDTH'(1);
            end
          end else begin
            hold_d = hold_q + HCW'(1);
          end
        end
      end
      TAIL: begin
        if (!stall) begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            state_d = FIN;
          end else begin
            hold_d = hold_q + HCW'(1);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE_BIN;
      passes_q   <= '0;
      pass_cnt_q <= '0;
      hold_q     <= '0;
      idx_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      mode_q     <= mode_d;
      passes_q   <= passes_d;
      pass_cnt_q <= pass_cnt_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
    end
  end

  stim_gen_pattern #(.WIDTH(WIDTH)) u_pattern (
    .mode    (mode_q),
    .vec_idx (idx_q),
    .stim    (pattern)
  );

  // Outputs decode directly from registered state, so reset clears them at once.
  assign valid   = (state_q == RUN);
  assign busy    = (state_q == RUN) || (state_q == TAIL);
  assign done    = (state_q == FIN);
  assign stim    = valid ? pattern : '0;
  assign vec_idx = idx_q;

endmodule
